// File: rtl/freq_gen.sv
// freq_gen: programmable square-wave generator (N pulses or continuous); FREQ_GEN_GATE_EN adds i_gate freeze input
module freq_gen #(
  parameter int PHASE_NBIT = 24,
  parameter int CNT_NBIT   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [PHASE_NBIT-1:0] i_high,
  input  logic [PHASE_NBIT-1:0] i_low,
  input  logic [CNT_NBIT-1:0]   i_cnt,
`ifdef FREQ_GEN_GATE_EN
  input  logic                  i_gate,
`endif
  output logic                  o_io,
  output logic [CNT_NBIT-1:0]   o_cnt,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;
  state_t state, state_n;
  logic [PHASE_NBIT-1:0] ctr, ctr_n, h, h_n, l, l_n;
  logic [CNT_NBIT-1:0] n, n_n, cnt_n, cnt_inc;
  logic done_n, run;
`ifdef FREQ_GEN_GATE_EN
  assign run = i_gate;
`else
  assign run = 1'b1;
`endif
  assign cnt_inc = o_cnt + 1'b1;
  // next-state: start beats stop beats phase advance; phase lengths of 0 are clamped to 1 at latch time
  always_comb begin
    state_n = state;
    ctr_n   = ctr;
    h_n     = h;
    l_n     = l;
    n_n     = n;
    cnt_n   = o_cnt;
    done_n  = done;
    if (start) begin
      h_n     = (i_high == '0) ? PHASE_NBIT'(1) : i_high;
      l_n     = (i_low == '0) ? PHASE_NBIT'(1) : i_low;
      n_n     = i_cnt;
      cnt_n   = '0;
      done_n  = 1'b0;
      ctr_n   = '0;
      state_n = S_HIGH;
    end else if (stop && state != S_IDLE) begin
      state_n = S_IDLE;
      done_n  = 1'b1;
      ctr_n   = '0;
    end else if (run && state == S_HIGH) begin
      ctr_n   = (ctr == h - 1'b1) ? '0 : ctr + 1'b1;
      state_n = (ctr == h - 1'b1) ? S_LOW : S_HIGH;
    end else if (run && state == S_LOW) begin
      ctr_n = (ctr == l - 1'b1) ? '0 : ctr + 1'b1;
      if (ctr == l - 1'b1) begin
        cnt_n   = cnt_inc;
        done_n  = (n != '0) && (cnt_inc == n);
        state_n = done_n ? S_IDLE : S_HIGH;
      end
    end
  end
  // state and registered outputs; o_io/busy follow the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ctr   <= '0;
      h     <= '0;
      l     <= '0;
      n     <= '0;
      o_cnt <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      o_io  <= 1'b0;
    end else begin
      state <= state_n;
      ctr   <= ctr_n;
      h     <= h_n;
      l     <= l_n;
      n     <= n_n;
      o_cnt <= cnt_n;
      done  <= done_n;
      busy  <= state_n != S_IDLE;
      o_io  <= state_n == S_HIGH;
    end
  end
endmodule

// File: tb/tb_freq_gen.sv
// tb_freq_gen: directed scenarios plus random start/stop/params checked against a time-since-start waveform model
module tb_freq_gen;
  logic clk = 0, rst = 0, start = 0, stop = 0, gate = 1;
  logic [23:0] i_high = 0, i_low = 0;
  logic [15:0] i_cnt = 0;
  logic o_io, busy, done;
  logic [15:0] o_cnt;
  int total = 0, bad = 0;
  bit m_run = 0, m_done = 0;
  longint m_k = 0, m_h = 1, m_l = 1, m_n = 0, m_cnt = 0;

  freq_gen dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .i_high(i_high), .i_low(i_low), .i_cnt(i_cnt),
`ifdef FREQ_GEN_GATE_EN
    .i_gate(gate),
`endif
    .o_io(o_io), .o_cnt(o_cnt), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    longint p = m_h + m_l;
    chk("o_io", o_io, m_run ? ((m_k % p) < m_h) : 0);
    chk("busy", busy, m_run);
    chk("done", done, m_done);
    chk("o_cnt", o_cnt, m_run ? ((m_k / p) % 65536) : m_cnt);
  endtask

  task automatic step(input bit st, input bit sp, input bit g);
    bit eg;
    start = st;
    stop  = sp;
    gate  = g;
    @(posedge clk);
`ifdef FREQ_GEN_GATE_EN
    eg = g;
`else
    eg = 1;
`endif
    if (st) begin
      m_h = (i_high == 0) ? 1 : longint'(i_high);
      m_l = (i_low == 0) ? 1 : longint'(i_low);
      m_n = i_cnt;
      m_k = 0;
      m_run = 1;
      m_done = 0;
    end else if (m_run && sp) begin
      m_run = 0;
      m_done = 1;
      m_cnt = (m_k / (m_h + m_l)) % 65536;
    end else if (m_run && eg) begin
      m_k++;
      if (m_n != 0 && m_k >= m_n * (m_h + m_l)) begin
        m_run = 0;
        m_done = 1;
        m_cnt = m_n;
      end
    end
    #1;
    check_all();
    start = 0;
    stop = 0;
  endtask

  task automatic go(input int h, input int l, input int n);
    i_high = 24'(h);
    i_low  = 24'(l);
    i_cnt  = 16'(n);
    step(1, 0, 1);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 1);
  endtask

  initial begin
    rst = 1;
    #1;
    check_all();
    #12 rst = 0;
    @(negedge clk);
    check_all();
    idle(3);
    go(2, 3, 4);
    idle(25);
    chk("t1_cnt", o_cnt, 4);
    go(0, 0, 3);
    i_high = 9;
    idle(10);
    chk("t2_cnt", o_cnt, 3);
    go(4, 4, 0);
    idle(81);
    step(0, 1, 1);
    chk("t3_cnt", o_cnt, 10);
    chk("t3_done", done, 1);
    step(0, 1, 1);
    go(5, 5, 8);
    idle(32);
    go(1, 2, 2);
    idle(8);
    chk("t4_cnt", o_cnt, 2);
    go(3, 2, 0);
    idle(7);
    #2 rst = 1;
    m_run = 0; m_done = 0; m_cnt = 0;
    #1;
    check_all();
    @(posedge clk);
    #1 rst = 0;
    idle(5);
`ifdef FREQ_GEN_GATE_EN
    go(3, 3, 1);
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    idle(10);
    chk("t6_done", done, 1);
`endif
    for (int i = 0; i < 4000; i++) begin
      bit st = ($urandom_range(0, 39) == 0) || (!m_run && $urandom_range(0, 7) == 0);
      bit sp = $urandom_range(0, 59) == 0;
      bit g = $urandom_range(0, 3) != 0;
      if (st) begin
        i_high = 24'($urandom_range(0, 4));
        i_low  = 24'($urandom_range(0, 4));
        i_cnt  = 16'($urandom_range(0, 4));
      end
      step(st, sp, g);
      if ($urandom_range(0, 9) == 0) begin
        i_high = 24'($urandom_range(0, 9));
        i_low  = 24'($urandom_range(0, 9));
        i_cnt  = 16'($urandom_range(0, 9));
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
